// File: rtl/ps2_mouse_tracker_if.sv
// Bundle between the ps2rx byte receiver, the mouse tracker and the cursor overlay.
// The master drives received bytes and the slave returns the decoded cursor event.
interface ps2_mouse_tracker_if #(
  parameter int COORD_W = 10
) ();
  logic               rx_done_tick;
  logic [7:0]         rx_data;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic [2:0]         buttons;
  logic               pkt_valid;
  logic               sync_err;

  modport master (
    output rx_done_tick, rx_data,
    input  cursor_x, cursor_y, buttons, pkt_valid, sync_err
  );

  modport slave (
    input  rx_done_tick, rx_data,
    output cursor_x, cursor_y, buttons, pkt_valid, sync_err
  );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 stream-mode packets and tracks a clamped absolute cursor.
// Handles header resync, inter-byte timeout, enable gating and homing.
module ps2_mouse_tracker #(
  parameter int COORD_W  = 10,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int CURSOR_W = 10,
  parameter int CURSOR_H = 10,
  parameter int INIT_X   = 6,
  parameter int INIT_Y   = 6,
  parameter int Y_INVERT = 1,
  parameter int TIMEOUT  = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic home_i,
  ps2_mouse_tracker_if.slave bus
);

  localparam int SUM_W = COORD_W + 2;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(H_RES - CURSOR_W);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(V_RES - CURSOR_H);
  localparam logic [COORD_W-1:0] X_HOME = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y_HOME = COORD_W'(INIT_Y);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic               Y_NEG  = (Y_INVERT != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_BYTE0  = 2'd0,
    S_BYTE1  = 2'd1,
    S_BYTE2  = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [6:0]         hdr_q, hdr_d;     // header byte without its always-one sync bit
  logic [7:0]         b1_q, b1_d;
  logic [7:0]         b2_q, b2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] cursor_x_q, cursor_x_d;
  logic [COORD_W-1:0] cursor_y_q, cursor_y_d;
  logic [2:0]         buttons_q, buttons_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               sync_err_q, sync_err_d;
  logic               err_pend_q, err_pend_d;
  logic               err_now_s;
  logic signed [8:0]  dx_s, dy_s;

  // Adds (or subtracts) a 9-bit signed delta and clamps the result into [0, lim].
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] pos,
    input logic signed [8:0]  delta,
    input logic               neg,
    input logic [COORD_W-1:0] lim
  );
    logic signed [SUM_W-1:0] p_s;
    logic signed [SUM_W-1:0] d_s;
    logic signed [SUM_W-1:0] sum_s;
    p_s   = $signed({2'b00, pos});
    d_s   = $signed({{(SUM_W-9){delta[8]}}, delta});
    sum_s = neg ? (p_s - d_s) : (p_s + d_s);
    if (sum_s[SUM_W-1]) begin
      step_axis = '0;
    end else if (sum_s > $signed({2'b00, lim})) begin
      step_axis = lim;
    end else begin
      step_axis = sum_s[COORD_W-1:0];
    end
  endfunction

  // Overflow flags (hdr bits 6/5 = b0[7]/b0[6]) zero the matching axis.
  assign dx_s = hdr_q[5] ? 9'sd0 : $signed({hdr_q[3], b1_q});
  assign dy_s = hdr_q[6] ? 9'sd0 : $signed({hdr_q[4], b2_q});

  // Packet FSM, timeout, cursor arithmetic and output pulse generation.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    cnt_d       = cnt_q;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    buttons_d   = buttons_q;
    pkt_valid_d = 1'b0;
    err_pend_d  = 1'b0;
    err_now_s   = 1'b0;

    if (!en_i) begin
      state_d = S_BYTE0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BYTE0: begin
          if (bus.rx_done_tick && bus.rx_data[3]) begin
            hdr_d   = {bus.rx_data[7:4], bus.rx_data[2:0]};
            cnt_d   = '0;
            state_d = S_BYTE1;
          end else if (bus.rx_done_tick) begin
            err_now_s = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
        S_BYTE1, S_BYTE2: begin
          if (bus.rx_done_tick) begin
            cnt_d = '0;
            if (state_q == S_BYTE1) begin
              b1_d    = bus.rx_data;
              state_d = S_BYTE2;
            end else begin
              b2_d    = bus.rx_data;
              state_d = S_UPDATE;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            err_now_s = 1'b1;
            state_d   = S_BYTE0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_UPDATE: begin
          state_d     = S_BYTE0;
          cursor_x_d  = step_axis(cursor_x_q, dx_s, 1'b0, X_LIM);
          cursor_y_d  = step_axis(cursor_y_q, dy_s, Y_NEG, Y_LIM);
          buttons_d   = hdr_q[2:0];
          pkt_valid_d = 1'b1;
          // A dropped tick reports one cycle late so it never overlaps pkt_valid.
          err_pend_d  = bus.rx_done_tick;
        end
        default: begin
          state_d = S_BYTE0;
          cnt_d   = '0;
        end
      endcase
    end

    if (home_i) begin
      cursor_x_d = X_HOME;
      cursor_y_d = Y_HOME;
    end else begin
      cursor_x_d = cursor_x_d;
    end

    sync_err_d = err_now_s | err_pend_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BYTE0;
      hdr_q       <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      cnt_q       <= '0;
      cursor_x_q  <= X_HOME;
      cursor_y_q  <= Y_HOME;
      buttons_q   <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      cnt_q       <= cnt_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      buttons_q   <= buttons_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign bus.cursor_x  = cursor_x_q;
  assign bus.cursor_y  = cursor_y_q;
  assign bus.buttons   = buttons_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: fixed packet table, corner-case
// sequences and random packets against an arithmetic cursor model.
module tb_ps2_mouse_tracker;
  localparam int TO   = 40;
  localparam int XMAX = 630;
  localparam int YMAX = 470;

  logic clk = 1'b0;
  logic rst_n, en, home;
  int   pass_cnt = 0, chk_cnt = 0;
  int   err_cnt = 0, both_cnt = 0;
  int   mx, my, mb;

  ps2_mouse_tracker_if #(.COORD_W(10)) bus ();

  ps2_mouse_tracker #(
    .COORD_W(10), .H_RES(640), .V_RES(480), .CURSOR_W(10), .CURSOR_H(10),
    .INIT_X(6), .INIT_Y(6), .Y_INVERT(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .home_i(home), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the active edge (pre-update values).
  always @(posedge clk) begin
    if (bus.sync_err) err_cnt <= err_cnt + 1;
    if (bus.sync_err && bus.pkt_valid) both_cnt <= both_cnt + 1;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int ex, ey, eb;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dx, XMAX);
    my = clampi(my - dy, YMAX);
    mb = int'(b0[2:0]);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int gap, input int ex, input int ey, input int eb);
    send_byte(b0);
    repeat (gap) @(negedge clk);
    send_byte(b1);
    repeat (gap) @(negedge clk);
    send_byte(b2);
    chk("pkt_early", int'(bus.pkt_valid), 0);
    @(negedge clk);
    chk("pkt_latency", int'(bus.pkt_valid), 1);
    chk("cursor_x", int'(bus.cursor_x), ex);
    chk("cursor_y", int'(bus.cursor_y), ey);
    chk("buttons", int'(bus.buttons), eb);
    @(negedge clk);
    chk("pkt_once", int'(bus.pkt_valid), 0);
  endtask

  task automatic pkt_model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap);
    model_apply(b0, b1, b2);
    send_pkt(b0, b1, b2, gap, mx, my, mb);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [7:0] r0, r1, r2;
    tbl[0]  = '{8'h08, 8'h05, 8'h03,  11,   3, 0};
    tbl[1]  = '{8'h19, 8'hF0, 8'h00,   0,   3, 1};
    tbl[2]  = '{8'h08, 8'h7F, 8'h00, 127,   3, 0};
    tbl[3]  = '{8'h28, 8'h00, 8'hFF, 127,   4, 0};
    tbl[4]  = '{8'h08, 8'hFF, 8'h00, 382,   4, 0};
    tbl[5]  = '{8'h08, 8'hFF, 8'h00, 630,   4, 0};
    tbl[6]  = '{8'h48, 8'h7F, 8'h00, 630,   4, 0};
    tbl[7]  = '{8'h0F, 8'h00, 8'h00, 630,   4, 7};
    tbl[8]  = '{8'h88, 8'h00, 8'h80, 630,   4, 0};
    tbl[9]  = '{8'h28, 8'h00, 8'h01, 630, 259, 0};
    tbl[10] = '{8'h08, 8'h00, 8'hE0, 630,  35, 0};
    tbl[11] = '{8'h28, 8'h00, 8'h00, 630, 291, 0};
    tbl[12] = '{8'h28, 8'h00, 8'h00, 630, 470, 0};
    tbl[13] = '{8'h08, 8'h00, 8'h7F, 630, 343, 0};

    rst_n = 1'b0; en = 1'b1; home = 1'b0;
    bus.rx_done_tick = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(bus.cursor_x), 6);
    chk("rst_y", int'(bus.cursor_y), 6);
    chk("rst_btn", int'(bus.buttons), 0);
    chk("rst_pkt", int'(bus.pkt_valid), 0);
    chk("rst_err", int'(bus.sync_err), 0);

    for (int i = 0; i < 14; i++) begin
      send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2, 0, tbl[i].ex, tbl[i].ey, tbl[i].eb);
    end
    mx = 630; my = 343; mb = 0;

    // Header without sync bit is rejected.
    e0 = err_cnt;
    send_byte(8'h00);
    @(negedge clk);
    chk("junk_err", err_cnt - e0, 1);
    pkt_model(8'h09, 8'hF6, 8'h02, 1);

    // Inter-byte timeout discards the partial packet.
    send_byte(8'h08);
    repeat (TO - 1) @(negedge clk);
    chk("to_early", int'(bus.sync_err), 0);
    @(negedge clk);
    chk("to_pulse", int'(bus.sync_err), 1);
    pkt_model(8'h18, 8'hFF, 8'h01, 0);

    // Enable dropped mid-packet: silent return to header hunt.
    e0 = err_cnt;
    send_byte(8'h08);
    send_byte(8'h05);
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    @(negedge clk) en = 1'b1;
    chk("en_noerr", err_cnt - e0, 0);
    pkt_model(8'h08, 8'h01, 8'h01, 0);

    // Tick during UPDATE is dropped; its sync_err follows pkt_valid.
    send_byte(8'h0A);
    send_byte(8'h02);
    @(negedge clk); bus.rx_done_tick = 1'b1; bus.rx_data = 8'h02;
    @(negedge clk); bus.rx_data = 8'h08;
    @(negedge clk); bus.rx_done_tick = 1'b0;
    model_apply(8'h0A, 8'h02, 8'h02);
    chk("upd_pkt", int'(bus.pkt_valid), 1);
    chk("upd_err_lo", int'(bus.sync_err), 0);
    chk("upd_x", int'(bus.cursor_x), mx);
    @(negedge clk);
    chk("upd_pkt_lo", int'(bus.pkt_valid), 0);
    chk("upd_err", int'(bus.sync_err), 1);
    pkt_model(8'h08, 8'h01, 8'h01, 0);

    // home in the UPDATE cycle wins over the motion update.
    send_byte(8'h0A);
    send_byte(8'h03);
    @(negedge clk); bus.rx_done_tick = 1'b1; bus.rx_data = 8'h03;
    @(negedge clk); bus.rx_done_tick = 1'b0; home = 1'b1;
    @(negedge clk); home = 1'b0;
    chk("home_pkt", int'(bus.pkt_valid), 1);
    chk("home_x", int'(bus.cursor_x), 6);
    chk("home_y", int'(bus.cursor_y), 6);
    chk("home_btn", int'(bus.buttons), 2);
    mx = 6; my = 6; mb = 2;

    // Random headers, junk bytes and inter-byte gaps against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r0 = 8'($urandom) & 8'hF7;
        e0 = err_cnt;
        send_byte(r0);
        @(negedge clk);
        chk("rnd_junk", err_cnt - e0, 1);
      end else begin
        r0 = 8'($urandom) | 8'h08;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        pkt_model(r0, r1, r2, $urandom_range(0, 3));
      end
    end

    // Asynchronous reset mid-packet.
    send_byte(8'h18);
    send_byte(8'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(bus.cursor_x), 6);
    chk("arst_y", int'(bus.cursor_y), 6);
    chk("arst_btn", int'(bus.buttons), 0);
    @(negedge clk) rst_n = 1'b1;
    mx = 6; my = 6; mb = 0;
    pkt_model(8'h08, 8'h01, 8'h01, 0);

    @(negedge clk);
    chk("pkt_err_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
